// File: rtl/maria_line_buffer.sv
// Ping-pong line RAM between the Maria DMA engine and the palette lookup.
// DMA fills the write bank while the display bank streams out and is cleared behind the read.
module maria_line_buffer #(
  parameter int HPIX_START = 93,
  parameter int NUM_PIX    = 160,
  parameter int DW         = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mclk0,
  input  logic [9:0]    col,
  input  logic          lrc,
  input  logic          kangaroo,
  input  logic          wr_en,
  input  logic [7:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] pix_index,
  output logic          pix_active,
  output logic          disp_sel,
  output logic          clear_busy
);

  localparam logic [9:0] HPIX_START_W = 10'(HPIX_START);
  localparam logic [9:0] WIN_LEN      = 10'(2 * NUM_PIX);
  localparam logic [7:0] NUM_PIX_W    = 8'(NUM_PIX);
  localparam logic [7:0] LAST_ADDR    = 8'(NUM_PIX - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [7:0]    clr_addr;
  logic [DW-1:0] bank0 [NUM_PIX];
  logic [DW-1:0] bank1 [NUM_PIX];

  // Colour 0 is transparent unless kangaroo mode forces it to be stored.
  function automatic logic dma_opaque(input logic [DW-1:0] d, input logic k);
    return (d[1:0] != 2'b00) || k;
  endfunction

  logic [9:0]    off_p0;
  logic          in_win_p0;
  logic [7:0]    rd_addr_p0;
  logic [DW-1:0] rd_data_p0;
  logic          clr_rd_p0;
  logic          dma_we_p0;

  // Stage p0: column decode, display-bank read, write qualification
  always_comb begin
    off_p0     = col - HPIX_START_W;
    in_win_p0  = off_p0 < WIN_LEN;
    rd_addr_p0 = in_win_p0 ? off_p0[8:1] : 8'd0;
    rd_data_p0 = disp_sel ? bank1[rd_addr_p0] : bank0[rd_addr_p0];
    clr_rd_p0  = (state == RUN) && mclk0 && in_win_p0 && off_p0[0];
    dma_we_p0  = (state == RUN) && wr_en && (wr_addr < NUM_PIX_W)
                 && dma_opaque(wr_data, kangaroo);
  end

  logic          b0_we,   b1_we;
  logic [7:0]    b0_addr, b1_addr;
  logic [DW-1:0] b0_data, b1_data;

  // The write bank only sees DMA and the display bank only sees the read-clear,
  // so each bank needs just one write port.
  always_comb begin
    b0_we   = 1'b0;
    b1_we   = 1'b0;
    b0_addr = 8'd0;
    b1_addr = 8'd0;
    b0_data = '0;
    b1_data = '0;
    if (state == CLEAR) begin
      b0_we   = 1'b1;
      b1_we   = 1'b1;
      b0_addr = clr_addr;
      b1_addr = clr_addr;
    end else if (disp_sel) begin
      b0_we   = dma_we_p0;
      b0_addr = wr_addr;
      b0_data = wr_data;
      b1_we   = clr_rd_p0;
      b1_addr = rd_addr_p0;
    end else begin
      b1_we   = dma_we_p0;
      b1_addr = wr_addr;
      b1_data = wr_data;
      b0_we   = clr_rd_p0;
      b0_addr = rd_addr_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (b0_we) bank0[b0_addr] <= b0_data;
    if (b1_we) bank1[b1_addr] <= b1_data;
  end

  // Stage p1: registered pixel output, bank swap, clear sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clr_addr   <= 8'd0;
      disp_sel   <= 1'b0;
      pix_index  <= '0;
      pix_active <= 1'b0;
      clear_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          pix_index  <= '0;
          pix_active <= 1'b0;
          disp_sel   <= 1'b0;
          if (clr_addr == LAST_ADDR) begin
            state      <= RUN;
            clr_addr   <= 8'd0;
            clear_busy <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 8'd1;
          end
        end
        RUN: begin
          if (mclk0) begin
            pix_index  <= in_win_p0 ? rd_data_p0 : '0;
            pix_active <= in_win_p0;
            if (lrc) disp_sel <= ~disp_sel;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: doc/maria_line_buffer.md
Name: maria_line_buffer

Overview:
- Double-buffered (ping-pong) line RAM sitting directly downstream of the video timing generator and beside the Maria DMA engine.
- DMA fills the write bank with 5-bit palette/colour indices for line N+1 while the display bank streams line N to the palette lookup, paced by the timing column counter.
- Banks swap on the line-reset-count pulse. Each displayed entry is cleared after it is read, so a bank is blank by the time it becomes the write bank.

Parameters:
HPIX_START, 93, column at which pixel 0 begins (border end)
NUM_PIX, 160, pixels per line; each pixel spans 2 column counts
DW, 5, entry width: {palette[2:0], colour[1:0]}

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
mclk0  in  1  pixel-clock enable; col advances on it
col  in  10  horizontal column from timing generator
lrc  in  1  line-reset-count pulse; swap banks
kangaroo  in  1  1 = colour-0 writes are stored (not transparent)
wr_en  in  1  DMA write strobe, any clk cycle
wr_addr  in  8  DMA horizontal pixel position
wr_data  in  DW  DMA pixel value
pix_index  out  DW  registered display pixel value
pix_active  out  1  pix_index lies within the 160-pixel window
disp_sel  out  1  bank currently displayed (other bank is written)
clear_busy  out  1  post-reset clear sequence in progress

Behaviour:
- Storage: two banks of NUM_PIX x DW. Bank disp_sel is read-only to DMA. Bank ~disp_sel is DMA-writable.
- FSM has two states, CLEAR and RUN.
  - Reset enters CLEAR with clr_addr=0.
  - CLEAR writes 0 to entry clr_addr of both banks every clk, with no mclk0 qualification.
  - At clr_addr==NUM_PIX-1, CLEAR moves to RUN on the next clk. Duration is exactly 160 clks.
  - clear_busy=1 throughout CLEAR.
  - Reset asserted mid-CLEAR or mid-RUN restarts CLEAR at 0.
- Reset values: disp_sel=0, pix_index=0, pix_active=0, clear_busy=1.
- In CLEAR:
  - wr_en is ignored.
  - lrc is ignored; disp_sel holds 0.
  - pix_index=0 and pix_active=0.
- Write path (RUN):
  - The write takes effect when wr_en=1, wr_addr<NUM_PIX, and (wr_data[1:0]!=0 or kangaroo=1).
  - It writes wr_data to bank ~disp_sel[wr_addr] at the clk edge.
  - wr_addr>=NUM_PIX is discarded (off-screen, no wrap).
  - A transparent write leaves the existing entry unchanged.
- Swap (RUN): on a clk with mclk0 & lrc, disp_sel toggles.
  - A wr_en in that same clk targets the pre-toggle write bank.
- Read path (RUN): on a clk with mclk0=1, let off=col-HPIX_START.
  - If 0<=off<2*NUM_PIX: p=off>>1, pix_index<=bank disp_sel[p], pix_active<=1.
  - Otherwise pix_index<=0 and pix_active<=0.
  - Latency is 1 clk after the mclk0 cycle that presents col.
  - Outputs hold between mclk0 enables.
- Clear-after-read: on the mclk0 cycle where off is odd and in the window, bank disp_sel[off>>1] is written 0 at that edge.
  - The registered pix_index from the even cycle is unaffected.
  - The odd cycle re-reads the same entry. Its read happens before the clear (read-before-write), so pix_index keeps the value.
- Both banks have independent write ports: the DMA write targets ~disp_sel and the clear targets disp_sel, so they never collide.
- Arithmetic: off is computed in 10 bits unsigned. col<HPIX_START underflows to a large value and falls outside the window.

Test Plan:
1. Reset, run 170 clks with wr_en=1 -> clear_busy high for exactly 160 clks, both banks read all 0, and the writes issued during CLEAR are absent afterwards.
2. RUN with disp_sel=0: write addr 0=5'h05 and addr 159=5'h1F, pulse lrc with mclk0, sweep col 93..413 -> disp_sel=1.
   - col 93/94 gives pix_index=05 with pix_active=1.
   - col 411/412 gives 1F.
   - col 413 gives pix_active=0.
3. After the scenario-2 line, pulse lrc again -> former display bank (now write bank) reads all 0 on the next display pass (clear-after-read verified).
4. kangaroo=0: write addr 10=5'h07, then addr 10=5'h04 -> displays 07. Repeat with kangaroo=1 -> displays 04.
5. wr_addr=160 and 255 with data 5'h03 -> no entry changes. Same-clk mclk0&lrc and wr_en to addr 20 -> data appears in the bank that just became the display bank.
6. Assert reset mid-line in RUN with a populated bank -> outputs return to reset values next clk, CLEAR restarts at 0, and all entries are 0 after 160 clks.
